bkm_multi_step_checker: RTL

- Parametrised successor to the single-step BKM checker. Compares NCH result channels against testbench-expected values every enabled cycle.
- Per channel it reports the registered signed delta, warning and error flags, and running signed min/max deltas.
- Globally it keeps saturating sample, warning and error counters, and captures a sticky record of the first error.
- Sits in the bkm verification environment, fed by the step/iteration benches.

---
 rtl/bkm_multi_step_checker_if.sv | 40 ++++
 rtl/bkm_multi_step_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bkm_multi_step_checker_if.sv
// Sample/result bundle for the multi-channel BKM checker. The bench drives the
// expected/actual vectors; the checker returns flags, deltas, statistics and the first-error record.
interface bkm_multi_step_checker_if #(
    parameter int NCH   = 4,
    parameter int W     = 64,
    parameter int LOG2N = 6,
    parameter int CNT_W = 32,
    parameter int CH_W  = 2
);
    logic                 enable;
    logic [LOG2N-1:0]     tb_n;
    logic [NCH*W-1:0]     tb_vec;
    logic [NCH*W-1:0]     res_vec;
    logic [NCH-1:0]       war_vec;
    logic [NCH-1:0]       err_vec;
    logic [NCH*W-1:0]     delta_vec;
    logic [NCH*W-1:0]     min_delta_vec;
    logic [NCH*W-1:0]     max_delta_vec;
    logic [CNT_W-1:0]     sample_cnt;
    logic [CNT_W-1:0]     war_cnt;
    logic [CNT_W-1:0]     err_cnt;
    logic                 first_err_valid;
    logic [CH_W-1:0]      first_err_ch;
    logic [LOG2N-1:0]     first_err_n;
    logic [W-1:0]         first_err_delta;

    modport master (
        output enable, tb_n, tb_vec, res_vec,
        input  war_vec, err_vec, delta_vec, min_delta_vec, max_delta_vec,
               sample_cnt, war_cnt, err_cnt,
               first_err_valid, first_err_ch, first_err_n, first_err_delta
    );

    modport slave (
        input  enable, tb_n, tb_vec, res_vec,
        output war_vec, err_vec, delta_vec, min_delta_vec, max_delta_vec,
               sample_cnt, war_cnt, err_cnt,
               first_err_valid, first_err_ch, first_err_n, first_err_delta
    );
endinterface

// File: rtl/bkm_multi_step_checker.sv
// Multi-channel BKM result checker. It computes per-channel signed deltas, tolerance flags and min/max,
// keeps saturating sample/warning/error counters, and captures the first error it sees.
module bkm_msc_lane #(
    parameter int W       = 64,
    parameter int WAR_TOL = 1,
    parameter int ERR_TOL = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         srst,
    input  logic         i_en,
    input  logic         i_seeded,
    input  logic [W-1:0] i_tb,
    input  logic [W-1:0] i_res,
    output logic         o_war,
    output logic         o_err,
    output logic [W-1:0] o_delta,
    output logic         o_war_q,
    output logic         o_err_q,
    output logic [W-1:0] o_delta_q,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_max
);
    localparam logic [W-1:0] L_WAR = W'(WAR_TOL);
    localparam logic [W-1:0] L_ERR = W'(ERR_TOL);

    logic [W-1:0] w_delta;
    logic [W-1:0] w_mag;
    logic         r_war, r_err;
    logic [W-1:0] r_delta, r_min, r_max;

    // The most-negative delta negates to itself. Read unsigned, that is 2^(W-1), so it always flags.
    assign w_delta = i_res - i_tb;
    assign w_mag   = w_delta[W-1] ? (~w_delta + 1'b1) : w_delta;
    assign o_war   = w_mag > L_WAR;
    assign o_err   = w_mag > L_ERR;
    assign o_delta = w_delta;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_war   <= 1'b0;
            r_err   <= 1'b0;
            r_delta <= '0;
            r_min   <= '0;
            r_max   <= '0;
        end else if (srst) begin
            r_war   <= 1'b0;
            r_err   <= 1'b0;
            r_delta <= '0;
            r_min   <= '0;
            r_max   <= '0;
        end else if (i_en) begin
            r_war   <= o_war;
            r_err   <= o_err;
            r_delta <= w_delta;
            if (!i_seeded || ($signed(w_delta) < $signed(r_min))) r_min <= w_delta;
            if (!i_seeded || ($signed(w_delta) > $signed(r_max))) r_max <= w_delta;
        end else begin
            r_war <= 1'b0;
            r_err <= 1'b0;
        end
    end

    assign o_war_q   = r_war;
    assign o_err_q   = r_err;
    assign o_delta_q = r_delta;
    assign o_min     = r_min;
    assign o_max     = r_max;
endmodule

module bkm_multi_step_checker #(
    parameter int NCH     = 4,
    parameter int W       = 64,
    parameter int LOG2N   = 6,
    parameter int CNT_W   = 32,
    parameter int WAR_TOL = 1,
    parameter int ERR_TOL = 4,
    parameter int CH_W    = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      srst,
    bkm_multi_step_checker_if.slave   bus
);
    logic                     r_seeded;
    logic [NCH-1:0]           w_war, w_err, w_war_q, w_err_q;
    logic [NCH-1:0][W-1:0]    w_delta, w_delta_q, w_min, w_max;
    logic [CNT_W-1:0]         r_sample_cnt, r_war_cnt, r_err_cnt;
    logic                     r_fe_valid;
    logic [CH_W-1:0]          r_fe_ch;
    logic [LOG2N-1:0]         r_fe_n;
    logic [W-1:0]             r_fe_delta;
    logic [CH_W-1:0]          w_fe_ch;
    logic [W-1:0]             w_fe_delta;

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        bkm_msc_lane #(.W(W), .WAR_TOL(WAR_TOL), .ERR_TOL(ERR_TOL)) u_lane (
            .clk       (clk),
            .arst      (arst),
            .srst      (srst),
            .i_en      (bus.enable),
            .i_seeded  (r_seeded),
            .i_tb      (bus.tb_vec[g*W +: W]),
            .i_res     (bus.res_vec[g*W +: W]),
            .o_war     (w_war[g]),
            .o_err     (w_err[g]),
            .o_delta   (w_delta[g]),
            .o_war_q   (w_war_q[g]),
            .o_err_q   (w_err_q[g]),
            .o_delta_q (w_delta_q[g]),
            .o_min     (w_min[g]),
            .o_max     (w_max[g])
        );
    end

    // Scan from the top down so the lowest erroring channel wins.
    always_comb begin
        w_fe_ch    = '0;
        w_fe_delta = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_err[k]) begin
                w_fe_ch    = CH_W'(k);
                w_fe_delta = w_delta[k];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_seeded     <= 1'b0;
            r_sample_cnt <= '0;
            r_war_cnt    <= '0;
            r_err_cnt    <= '0;
            r_fe_valid   <= 1'b0;
            r_fe_ch      <= '0;
            r_fe_n       <= '0;
            r_fe_delta   <= '0;
        end else if (srst) begin
            r_seeded     <= 1'b0;
            r_sample_cnt <= '0;
            r_war_cnt    <= '0;
            r_err_cnt    <= '0;
            r_fe_valid   <= 1'b0;
            r_fe_ch      <= '0;
            r_fe_n       <= '0;
            r_fe_delta   <= '0;
        end else if (bus.enable) begin
            r_seeded <= 1'b1;
            if (r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + 1'b1;
            if ((|w_war) && (r_war_cnt != '1)) r_war_cnt <= r_war_cnt + 1'b1;
            if ((|w_err) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
            if ((|w_err) && !r_fe_valid) begin
                r_fe_valid <= 1'b1;
                r_fe_ch    <= w_fe_ch;
                r_fe_n     <= bus.tb_n;
                r_fe_delta <= w_fe_delta;
            end
        end
    end

    assign bus.war_vec         = w_war_q;
    assign bus.err_vec         = w_err_q;
    assign bus.delta_vec       = w_delta_q;
    assign bus.min_delta_vec   = w_min;
    assign bus.max_delta_vec   = w_max;
    assign bus.sample_cnt      = r_sample_cnt;
    assign bus.war_cnt         = r_war_cnt;
    assign bus.err_cnt         = r_err_cnt;
    assign bus.first_err_valid = r_fe_valid;
    assign bus.first_err_ch    = r_fe_ch;
    assign bus.first_err_n     = r_fe_n;
    assign bus.first_err_delta = r_fe_delta;
endmodule
